// File: rtl/snake_move_controller.sv
// Snake head sequencer: divides the board clock into move ticks, commits a direction,
// advances the head and handles wall/self collisions, growth, pause and restart.
module snake_move_controller #(
  parameter int unsigned TICK_DIV = 25000000,
  parameter int unsigned GRID_W   = 16,
  parameter int unsigned GRID_H   = 16,
  parameter int unsigned COORD_W  = 4,
  parameter int unsigned WRAP     = 0,
  parameter int unsigned INIT_LEN = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               pause,
  input  logic [3:0]         direcao,
  input  logic               grow,
  input  logic               self_hit,
  output logic [COORD_W-1:0] head_x,
  output logic [COORD_W-1:0] head_y,
  output logic               step,
  output logic [7:0]         length,
  output logic [1:0]         state,
  output logic               game_over
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0]    CntMax = CntW'(TICK_DIV - 1);
  localparam logic [COORD_W-1:0] XMax   = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] YMax   = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] XInit  = COORD_W'(GRID_W / 2);
  localparam logic [COORD_W-1:0] YInit  = COORD_W'(GRID_H / 2);
  localparam logic [7:0]         LenInit = 8'(INIT_LEN);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StOver  = 2'b11
  } state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [COORD_W-1:0] head_x_q, head_y_q;
  logic [3:0]         dir_q;
  logic [7:0]         len_q;
  logic               step_q, grow_pend_q, start_q, game_over_q;

  logic               start_rise, tick, cand_ok, off_board;
  logic [3:0]         chosen;
  logic [COORD_W-1:0] next_x, next_y;

  assign start_rise = start & ~start_q;
  assign tick       = (cnt_q == CntMax);
  // A reversal would drive the head straight into its own neck, so it is refused.
  assign cand_ok    = $onehot(direcao) && (direcao != {dir_q[1:0], dir_q[3:2]});
  assign chosen     = cand_ok ? direcao : dir_q;

  // off_board flags a wall crossing; next_x/next_y already hold the wrapped position.
  always_comb begin
    next_x    = head_x_q;
    next_y    = head_y_q;
    off_board = 1'b0;
    case (chosen)
      4'b0001: begin
        if (head_y_q == '0) begin off_board = 1'b1; next_y = YMax; end
        else next_y = head_y_q - COORD_W'(1);
      end
      4'b0100: begin
        if (head_y_q == YMax) begin off_board = 1'b1; next_y = '0; end
        else next_y = head_y_q + COORD_W'(1);
      end
      4'b0010: begin
        if (head_x_q == '0) begin off_board = 1'b1; next_x = XMax; end
        else next_x = head_x_q - COORD_W'(1);
      end
      4'b1000: begin
        if (head_x_q == XMax) begin off_board = 1'b1; next_x = '0; end
        else next_x = head_x_q + COORD_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      head_x_q    <= XInit;
      head_y_q    <= YInit;
      dir_q       <= 4'b0001;
      len_q       <= LenInit;
      step_q      <= 1'b0;
      grow_pend_q <= 1'b0;
      start_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      start_q <= start;
      step_q  <= 1'b0;
      if ((state_q == StIdle || state_q == StOver) && start_rise) begin
        state_q     <= StRun;
        cnt_q       <= '0;
        head_x_q    <= XInit;
        head_y_q    <= YInit;
        dir_q       <= 4'b0001;
        len_q       <= LenInit;
        grow_pend_q <= 1'b0;
        game_over_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: cnt_q <= '0;
          StRun: begin
            if (grow) grow_pend_q <= 1'b1;
            if (self_hit) begin
              state_q     <= StOver;
              game_over_q <= 1'b1;
            end else if (pause) begin
              state_q <= StPause;
            end else begin
              cnt_q <= tick ? '0 : cnt_q + CntW'(1);
              if (tick) begin
                if (off_board && (WRAP == 0)) begin
                  state_q     <= StOver;
                  game_over_q <= 1'b1;
                end else begin
                  head_x_q <= next_x;
                  head_y_q <= next_y;
                  dir_q    <= chosen;
                  step_q   <= 1'b1;
                  // Overrides the set above: a grow on the step cycle is consumed now.
                  if (grow_pend_q || grow) begin
                    if (len_q != 8'hFF) len_q <= len_q + 8'd1;
                    grow_pend_q <= 1'b0;
                  end
                end
              end
            end
          end
          StPause: if (!pause) state_q <= StRun;
          StOver:  ;
        endcase
      end
    end
  end

  assign head_x    = head_x_q;
  assign head_y    = head_y_q;
  assign step      = step_q;
  assign length    = len_q;
  assign state     = state_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_snake_move_controller.sv
// Bench for snake_move_controller: a WRAP=0 and a WRAP=1 instance share stimulus and are
// compared every cycle against a grid-level game model, plus directed scenario checks.
module tb_snake_move_controller;

  localparam int TickDiv = 4;
  localparam int Grid    = 8;

  logic       clock = 1'b0;
  logic       reset_n, start, pause, grow, self_hit;
  logic [3:0] direcao;
  logic [2:0] hx  [2];
  logic [2:0] hy  [2];
  logic       stp [2];
  logic [7:0] len [2];
  logic [1:0] st  [2];
  logic       go  [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: state code, head, length, direction index (0 up,1 left,2 down,3 right).
  int m_state [2], m_hx [2], m_hy [2], m_len [2], m_dir [2], m_cnt [2], m_gp [2], m_step [2];
  int m_startq;
  int dx [4] = '{0, -1, 0, 1};
  int dy [4] = '{-1, 0, 1, 0};

  always #5 clock = ~clock;

  snake_move_controller #(
    .TICK_DIV(TickDiv), .GRID_W(Grid), .GRID_H(Grid), .COORD_W(3), .WRAP(0), .INIT_LEN(3)
  ) u_dut_wall (
    .clock(clock), .reset_n(reset_n), .start(start), .pause(pause), .direcao(direcao),
    .grow(grow), .self_hit(self_hit), .head_x(hx[0]), .head_y(hy[0]), .step(stp[0]),
    .length(len[0]), .state(st[0]), .game_over(go[0])
  );

  snake_move_controller #(
    .TICK_DIV(TickDiv), .GRID_W(Grid), .GRID_H(Grid), .COORD_W(3), .WRAP(1), .INIT_LEN(3)
  ) u_dut_wrap (
    .clock(clock), .reset_n(reset_n), .start(start), .pause(pause), .direcao(direcao),
    .grow(grow), .self_hit(self_hit), .head_x(hx[1]), .head_y(hy[1]), .step(stp[1]),
    .length(len[1]), .state(st[1]), .game_over(go[1])
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_init(input int w);
    m_hx[w]  = Grid / 2;
    m_hy[w]  = Grid / 2;
    m_len[w] = 3;
    m_dir[w] = 0;
    m_cnt[w] = 0;
    m_gp[w]  = 0;
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      model_init(w);
      m_state[w] = 0;
      m_step[w]  = 0;
    end
    m_startq = 0;
  endtask

  // Applies the current inputs to the model as one clock edge.
  task automatic model_edge();
    bit sr;
    int d, c, nx, ny;
    bit used;
    sr = start && (m_startq == 0);
    for (int w = 0; w < 2; w++) begin
      m_step[w] = 0;
      used = 0;
      if ((m_state[w] == 0 || m_state[w] == 3) && sr) begin
        model_init(w);
        m_state[w] = 1;
      end else if (m_state[w] == 0) begin
        m_cnt[w] = 0;
      end else if (m_state[w] == 1) begin
        if (self_hit) m_state[w] = 3;
        else if (pause) m_state[w] = 2;
        else if (m_cnt[w] == TickDiv - 1) begin
          m_cnt[w] = 0;
          d = m_dir[w];
          c = -1;
          for (int k = 0; k < 4; k++) if (direcao == (4'(1) << k)) c = k;
          if (c >= 0 && c != (m_dir[w] + 2) % 4) d = c;
          nx = m_hx[w] + dx[d];
          ny = m_hy[w] + dy[d];
          if (nx < 0 || nx >= Grid || ny < 0 || ny >= Grid) begin
            if (w == 0) m_state[w] = 3;
            nx = (nx + Grid) % Grid;
            ny = (ny + Grid) % Grid;
          end
          if (m_state[w] == 1) begin
            m_hx[w]   = nx;
            m_hy[w]   = ny;
            m_dir[w]  = d;
            m_step[w] = 1;
            if (m_gp[w] != 0 || grow) begin
              if (m_len[w] < 255) m_len[w]++;
              m_gp[w] = 0;
              used = 1;
            end
          end
        end else begin
          m_cnt[w]++;
        end
        if (grow && !used) m_gp[w] = 1;
      end else if (m_state[w] == 2) begin
        if (!pause) m_state[w] = 1;
      end
    end
    m_startq = start;
  endtask

  task automatic compare_all(input string pfx);
    for (int w = 0; w < 2; w++) begin
      check_eq($sformatf("%s_w%0d_state", pfx, w), int'(st[w]), m_state[w]);
      check_eq($sformatf("%s_w%0d_head_x", pfx, w), int'(hx[w]), m_hx[w]);
      check_eq($sformatf("%s_w%0d_head_y", pfx, w), int'(hy[w]), m_hy[w]);
      check_eq($sformatf("%s_w%0d_step", pfx, w), int'(stp[w]), m_step[w]);
      check_eq($sformatf("%s_w%0d_length", pfx, w), int'(len[w]), m_len[w]);
      check_eq($sformatf("%s_w%0d_game_over", pfx, w), int'(go[w]), int'(m_state[w] == 3));
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clock);
    #1;
    compare_all("cyc");
  endtask

  // Called 1 time unit after a rising edge; reset lands between edges.
  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all("rst");
    check_eq("rst_state_now", int'(st[0]), 0);
    check_eq("rst_head_now", int'({hx[0], hy[0]}), 8'h24);
    check_eq("rst_len_now", int'(len[0]), 3);
    #1 reset_n = 1'b1;
  endtask

  task automatic start_game();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  int grow_pat [3][4] = '{'{0, 1, 0, 0}, '{1, 0, 1, 0}, '{0, 0, 0, 1}};

  initial begin
    reset_n = 1'b0; start = 1'b0; pause = 1'b0; grow = 1'b0; self_hit = 1'b0;
    direcao = 4'b0001;
    model_reset();
    #12 reset_n = 1'b1;

    // Straight up: four moves to y=0, then the fifth tick hits the wall or wraps.
    cyc();
    start_game();
    check_eq("start_state", int'(st[0]), 1);
    check_eq("start_head", int'({hx[0], hy[0]}), 8'h24);
    check_eq("start_len", int'(len[0]), 3);
    repeat (4) cyc();
    check_eq("first_step", int'(stp[0]), 1);
    check_eq("first_y", int'(hy[0]), 3);
    repeat (4) cyc();
    check_eq("second_y", int'(hy[0]), 2);
    repeat (12) cyc();
    check_eq("wall_state", int'(st[0]), 3);
    check_eq("wall_game_over", int'(go[0]), 1);
    check_eq("wall_head_y", int'(hy[0]), 0);
    check_eq("wall_no_step", int'(stp[0]), 0);
    check_eq("wrap_head_y", int'(hy[1]), 7);
    check_eq("wrap_step", int'(stp[1]), 1);

    // Reversal and non-one-hot candidates on the tick cycle are refused.
    async_reset();
    start_game();
    direcao = 4'b0010; repeat (3) cyc();
    direcao = 4'b0100; cyc();
    check_eq("rev_y", int'(hy[0]), 3);
    check_eq("rev_x", int'(hx[0]), 4);
    direcao = 4'b0001; repeat (3) cyc();
    direcao = 4'b0011; cyc();
    check_eq("nonhot_y", int'(hy[0]), 2);
    check_eq("nonhot_x", int'(hx[0]), 4);
    direcao = 4'b0001;

    // Growth: single pulse, double pulse, pulse on the tick cycle.
    async_reset();
    direcao = 4'b0010;
    start_game();
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < 4; c++) begin
        grow = grow_pat[t][c][0];
        cyc();
      end
      grow = 1'b0;
      check_eq($sformatf("grow%0d_len", t), int'(len[0]), 4 + t);
      check_eq($sformatf("grow%0d_x", t), int'(hx[0]), 3 - t);
    end

    // Pause at counter 2, grow ignored while paused, then self_hit on the tick cycle.
    async_reset();
    direcao = 4'b0001;
    start_game();
    repeat (2) cyc();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      grow = (i == 4);
      cyc();
    end
    grow = 1'b0;
    check_eq("pause_state", int'(st[0]), 2);
    pause = 1'b0;
    cyc();
    check_eq("resume_state", int'(st[0]), 1);
    check_eq("pause_len", int'(len[0]), 3);
    start = 1'b1;
    cyc();
    self_hit = 1'b1;
    cyc();
    self_hit = 1'b0;
    check_eq("hit_state", int'(st[0]), 3);
    check_eq("hit_step", int'(stp[0]), 0);
    check_eq("hit_head_y", int'(hy[0]), 4);
    repeat (3) cyc();
    check_eq("held_start_state", int'(st[0]), 3);
    start = 1'b0; cyc();
    start = 1'b1; cyc();
    start = 1'b0;
    check_eq("restart_state", int'(st[0]), 1);
    check_eq("restart_head", int'({hx[0], hy[0]}), 8'h24);
    check_eq("restart_len", int'(len[0]), 3);

    // Randomized play against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) != 0) direcao = 4'(1) << $urandom_range(0, 3);
      else direcao = 4'($urandom);
      grow     = ($urandom_range(0, 9) == 0);
      self_hit = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      if ($urandom_range(0, 29) == 0) start = ~start;
      cyc();
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
